// File: rtl/led_pattern_shifter_if.sv
// Control/status bundle for led_pattern_shifter; i_step exists only with LED_SHIFTER_STEP_EN.
// The master drives the controls and the slave (the shifter) drives the LED outputs.
interface led_pattern_shifter_if #(
  parameter int N_LEDS     = 4,
  parameter int PRESCALE_W = 24
);
  logic                  i_enable;
  logic [PRESCALE_W-1:0] i_limit;
  logic [1:0]            i_mode;
  logic                  i_load;
  logic [N_LEDS-1:0]     i_pattern;
`ifdef LED_SHIFTER_STEP_EN
  logic                  i_step;
`endif
  logic [N_LEDS-1:0]     o_leds;
  logic                  o_tick;
  logic                  o_dir;

`ifdef LED_SHIFTER_STEP_EN
  modport master (output i_enable, i_limit, i_mode, i_load, i_pattern, i_step,
                  input  o_leds, o_tick, o_dir);
  modport slave  (input  i_enable, i_limit, i_mode, i_load, i_pattern, i_step,
                  output o_leds, o_tick, o_dir);
`else
  modport master (output i_enable, i_limit, i_mode, i_load, i_pattern,
                  input  o_leds, o_tick, o_dir);
  modport slave  (input  i_enable, i_limit, i_mode, i_load, i_pattern,
                  output o_leds, o_tick, o_dir);
`endif
endinterface

// File: rtl/led_pattern_shifter.sv
// LED pattern engine: prescaler plus rotate-right/left, ping-pong and fill/drain modes.
// Define LED_SHIFTER_STEP_EN to add the i_step single-shift input.
module led_pattern_shifter #(
  parameter int                N_LEDS       = 4,
  parameter int                PRESCALE_W   = 24,
  parameter logic [N_LEDS-1:0] INIT_PATTERN = N_LEDS'(1)
) (
  input logic                  clk,
  input logic                  i_ck_rst,
  led_pattern_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROR  = 2'b00,
    MODE_ROL  = 2'b01,
    MODE_PING = 2'b10,
    MODE_FILL = 2'b11
  } mode_t;

  // PH0 means LEFT in ping-pong and FILL in fill/drain; PH1 means RIGHT / DRAIN.
  typedef enum logic {
    PH0 = 1'b0,
    PH1 = 1'b1
  } phase_t;

  logic [N_LEDS-1:0]     leds_reg;
  logic [PRESCALE_W-1:0] cnt_reg;
  phase_t                phase_reg;
  mode_t                 mode_reg;
  logic                  tick_reg;
  logic                  dir_reg;

  logic [N_LEDS-1:0]     rot_r;
  logic [N_LEDS-1:0]     rot_l;
  logic [N_LEDS-1:0]     leds_next;
  phase_t                phase_eff;
  phase_t                phase_next;
  logic                  dir_next;
  logic                  tick;
  mode_t                 mode_in;

  assign mode_in = mode_t'(bus.i_mode);

  genvar gi;
  generate
    for (gi = 0; gi < N_LEDS; gi++) begin : g_rot
      assign rot_r[gi] = leds_reg[(gi + 1) % N_LEDS];
      assign rot_l[gi] = leds_reg[(gi + N_LEDS - 1) % N_LEDS];
    end
  endgenerate

`ifdef LED_SHIFTER_STEP_EN
  assign tick = bus.i_step | (bus.i_enable & (cnt_reg >= bus.i_limit));
`else
  assign tick = bus.i_enable & (cnt_reg >= bus.i_limit);
`endif

  // Next pattern/phase/direction if this cycle ticks; a mode change restarts the phase.
  always_comb begin
    phase_eff  = (mode_in != mode_reg) ? PH0 : phase_reg;
    leds_next  = leds_reg;
    phase_next = phase_eff;
    dir_next   = dir_reg;
    case (mode_in)
      MODE_ROR: begin
        leds_next = rot_r;
        dir_next  = 1'b1;
      end
      MODE_ROL: begin
        leds_next = rot_l;
        dir_next  = 1'b0;
      end
      MODE_PING: begin
        if (phase_eff == PH0) begin
          if (leds_reg[N_LEDS-1]) begin
            phase_next = PH1;
            leds_next  = rot_r;
            dir_next   = 1'b1;
          end else begin
            leds_next  = rot_l;
            dir_next   = 1'b0;
          end
        end else begin
          if (leds_reg[0]) begin
            phase_next = PH0;
            leds_next  = rot_l;
            dir_next   = 1'b0;
          end else begin
            leds_next  = rot_r;
            dir_next   = 1'b1;
          end
        end
      end
      MODE_FILL: begin
        dir_next = 1'b0;
        if (phase_eff == PH0) begin
          if (&leds_reg) begin
            phase_next = PH1;
            leds_next  = {leds_reg[N_LEDS-2:0], 1'b0};
          end else begin
            leds_next  = {leds_reg[N_LEDS-2:0], 1'b1};
          end
        end else begin
          if (~|leds_reg) begin
            phase_next = PH0;
            leds_next  = {leds_reg[N_LEDS-2:0], 1'b1};
          end else begin
            leds_next  = {leds_reg[N_LEDS-2:0], 1'b0};
          end
        end
      end
      default: leds_next = leds_reg;
    endcase
  end

  always_ff @(posedge clk or negedge i_ck_rst) begin
    if (!i_ck_rst) begin
      leds_reg  <= INIT_PATTERN;
      cnt_reg   <= '0;
      phase_reg <= PH0;
      mode_reg  <= MODE_ROR;
      tick_reg  <= 1'b0;
      dir_reg   <= 1'b0;
    end else if (bus.i_load) begin
      // A load swallows any tick due this cycle and restarts the prescaler.
      leds_reg  <= bus.i_pattern;
      cnt_reg   <= '0;
      phase_reg <= PH0;
      tick_reg  <= 1'b0;
    end else if (tick) begin
      leds_reg  <= leds_next;
      cnt_reg   <= '0;
      phase_reg <= phase_next;
      mode_reg  <= mode_in;
      tick_reg  <= 1'b1;
      dir_reg   <= dir_next;
    end else begin
      tick_reg <= 1'b0;
      if (bus.i_enable) begin
        cnt_reg <= cnt_reg + PRESCALE_W'(1);
      end
    end
  end

  assign bus.o_leds = leds_reg;
  assign bus.o_tick = tick_reg;
  assign bus.o_dir  = dir_reg;

endmodule

// File: tb/tb_led_pattern_shifter.sv
// Directed bench for led_pattern_shifter with a cycle-level reference model and literal checks.
// Build with LED_SHIFTER_STEP_EN defined to also exercise i_step.
module tb_led_pattern_shifter;
  localparam int N    = 4;
  localparam int PW   = 24;
  localparam int MASK = (1 << N) - 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  led_pattern_shifter_if #(.N_LEDS(N), .PRESCALE_W(PW)) bus ();

  led_pattern_shifter #(.N_LEDS(N), .PRESCALE_W(PW), .INIT_PATTERN(4'b0001)) dut (
    .clk      (clk),
    .i_ck_rst (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the pattern.
  int m_leds  = 1;
  int m_cnt   = 0;
  int m_phase = 0;
  int m_mode  = 0;
  int m_tick  = 0;
  int m_dir   = 0;

  function automatic int ror(input int v);
    return ((v >> 1) | ((v & 1) << (N - 1))) & MASK;
  endfunction

  function automatic int rol(input int v);
    return ((v << 1) | (v >> (N - 1))) & MASK;
  endfunction

  task automatic model_reset();
    m_leds = 1; m_cnt = 0; m_phase = 0; m_mode = 0; m_tick = 0; m_dir = 0;
  endtask

  task automatic model_edge();
    bit tk;
    int p;
    bit go_right;
    tk = bus.i_enable && (m_cnt >= int'(bus.i_limit));
`ifdef LED_SHIFTER_STEP_EN
    tk = tk || bus.i_step;
`endif
    if (bus.i_load) begin
      m_leds = int'(bus.i_pattern); m_cnt = 0; m_phase = 0; m_tick = 0;
    end else if (tk) begin
      p = (int'(bus.i_mode) == m_mode) ? m_phase : 0;
      m_mode = int'(bus.i_mode);
      m_tick = 1;
      m_cnt  = 0;
      case (m_mode)
        0: begin m_leds = ror(m_leds); m_dir = 1; end
        1: begin m_leds = rol(m_leds); m_dir = 0; end
        2: begin
          // The phase after a bounce step always equals the direction taken.
          go_right = (p == 0) ? m_leds[N-1] : !m_leds[0];
          m_leds = go_right ? ror(m_leds) : rol(m_leds);
          m_dir  = go_right;
          p      = go_right;
        end
        default: begin
          if (m_leds == ((p == 0) ? MASK : 0)) p = 1 - p;
          m_leds = ((m_leds << 1) | ((p == 0) ? 1 : 0)) & MASK;
          m_dir  = 0;
        end
      endcase
      m_phase = p;
    end else begin
      m_tick = 0;
      if (bus.i_enable) m_cnt++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else model_edge();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    checks += 3;
    if (bus.o_leds !== 4'(m_leds)) begin
      errors++; $display("FAIL model_leds t=%0t got %b want %b", $time, bus.o_leds, 4'(m_leds));
    end
    if (bus.o_tick !== 1'(m_tick)) begin
      errors++; $display("FAIL model_tick t=%0t got %b want %b", $time, bus.o_tick, 1'(m_tick));
    end
    if (bus.o_dir !== 1'(m_dir)) begin
      errors++; $display("FAIL model_dir t=%0t got %b want %b", $time, bus.o_dir, 1'(m_dir));
    end
  end

  task automatic check_lit(input string name, input logic [3:0] el, input logic et, input logic ed);
    checks += 3;
    if (bus.o_leds !== el) begin
      errors++; $display("FAIL %s o_leds got %b want %b", name, bus.o_leds, el);
    end
    if (bus.o_tick !== et) begin
      errors++; $display("FAIL %s o_tick got %b want %b", name, bus.o_tick, et);
    end
    if (bus.o_dir !== ed) begin
      errors++; $display("FAIL %s o_dir got %b want %b", name, bus.o_dir, ed);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [3:0] t2_leds [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  logic       t2_dir  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0] t3_leds [9] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                              4'b1100, 4'b1000, 4'b0000, 4'b0001};

  initial begin
    rst_n = 1'b0;
    bus.i_enable = 1'b0; bus.i_limit = PW'(2); bus.i_mode = 2'b00;
    bus.i_load = 1'b0; bus.i_pattern = 4'b0000;
`ifdef LED_SHIFTER_STEP_EN
    bus.i_step = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_lit("reset", 4'b0001, 1'b0, 1'b0);
    $display("reset: o_leds=%b", bus.o_leds);

    // T1: rotate right, limit 2
    rst_n = 1'b1; bus.i_enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i < 3)       check_lit("t1_pre",   4'b0001, 1'b0, 1'b0);
      else if (i == 3) check_lit("t1_tick1", 4'b1000, 1'b1, 1'b1);
      else if (i < 6)  check_lit("t1_gap",   4'b1000, 1'b0, 1'b1);
      else             check_lit("t1_tick2", 4'b0100, 1'b1, 1'b1);
    end
    $display("T1 rotate right: o_leds=%b", bus.o_leds);

    // T2: ping-pong from 0001, limit 0
    bus.i_load = 1'b1; bus.i_pattern = 4'b0001; bus.i_mode = 2'b10; bus.i_limit = PW'(0);
    @(negedge clk);
    check_lit("t2_load", 4'b0001, 1'b0, 1'b1);
    bus.i_load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check_lit("t2_step", t2_leds[i], 1'b1, t2_dir[i]);
    end
    $display("T2 ping-pong: o_leds=%b", bus.o_leds);

    // T3: fill/drain from 0000
    bus.i_load = 1'b1; bus.i_pattern = 4'b0000; bus.i_mode = 2'b11;
    @(negedge clk);
    check_lit("t3_load", 4'b0000, 1'b0, 1'b0);
    bus.i_load = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_lit("t3_step", t3_leds[i], 1'b1, 1'b0);
    end
    $display("T3 fill/drain: o_leds=%b", bus.o_leds);

    // T4: load during a tick cycle, then lower the limit below the count
    bus.i_load = 1'b1; bus.i_pattern = 4'b1010; bus.i_mode = 2'b00;
    @(negedge clk);
    check_lit("t4_load", 4'b1010, 1'b0, 1'b0);
    bus.i_load = 1'b0; bus.i_limit = PW'(2);
    @(negedge clk); check_lit("t4_c1", 4'b1010, 1'b0, 1'b0);
    @(negedge clk); check_lit("t4_c2", 4'b1010, 1'b0, 1'b0);
    @(negedge clk); check_lit("t4_tick", 4'b0101, 1'b1, 1'b1);
    bus.i_limit = PW'(10);
    repeat (7) @(negedge clk);
    check_lit("t4_cnt7", 4'b0101, 1'b0, 1'b1);
    bus.i_limit = PW'(2);
    @(negedge clk);
    check_lit("t4_lower", 4'b1010, 1'b1, 1'b1);
    $display("T4 load/limit: o_leds=%b", bus.o_leds);

    // T5: freeze mid-count, resume, then asynchronous reset
    @(negedge clk);
    bus.i_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_lit("t5_hold", 4'b1010, 1'b0, 1'b1);
    end
    bus.i_enable = 1'b1;
    @(negedge clk); check_lit("t5_resume", 4'b1010, 1'b0, 1'b1);
    @(negedge clk); check_lit("t5_tick", 4'b0101, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_lit("t5_async_rst", 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; bus.i_enable = 1'b0;
    $display("T5 hold/async reset: o_leds=%b", bus.o_leds);

`ifdef LED_SHIFTER_STEP_EN
    // T6: single forced step with the prescaler disabled
    @(negedge clk);
    bus.i_mode = 2'b01; bus.i_step = 1'b1;
    @(negedge clk);
    check_lit("t6_step", 4'b0010, 1'b1, 1'b0);
    bus.i_step = 1'b0;
    @(negedge clk);
    check_lit("t6_after", 4'b0010, 1'b0, 1'b0);
    $display("T6 step: o_leds=%b", bus.o_leds);
`endif

    // Mixed traffic checked by the model only
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      bus.i_enable  = ($urandom_range(0, 7) != 0);
      bus.i_limit   = PW'($urandom_range(0, 3));
      bus.i_mode    = 2'($urandom_range(0, 3));
      bus.i_load    = ($urandom_range(0, 9) == 0);
      bus.i_pattern = 4'($urandom_range(0, 15));
`ifdef LED_SHIFTER_STEP_EN
      bus.i_step    = ($urandom_range(0, 5) == 0);
`endif
    end
    @(negedge clk);
    $display("mixed traffic: o_leds=%b", bus.o_leds);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
